// File: rtl/br_flow_mux_select_reg.sv
// br_flow_mux_select_reg: registered dataflow mux with explicit select.
//
// One of NumRequesters ready-valid push interfaces, chosen by select_i, feeds a single
// pop interface through a 2-entry elastic buffer (main + skid). pop_valid_o and
// pop_data_o come straight from flops. push_ready_o depends only on flops, rst_n and
// select_i, so there is no path from pop_ready_i or push_valid_i to any output.
//
// Optional feature, enabled by defining BR_FLOW_MUX_SELECT_REG_SOURCE_ID_EN:
// adds pop_source_o, the select value captured when the popped entry was pushed.

module br_flow_mux_select_reg #(
    parameter int unsigned NumRequesters = 2,
    parameter int unsigned BitWidth      = 1,
    localparam int unsigned SelWidth     = $clog2(NumRequesters)
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic [SelWidth-1:0]                    select_i,
    output logic [NumRequesters-1:0]               push_ready_o,
    input  logic [NumRequesters-1:0]               push_valid_i,
    input  logic [NumRequesters-1:0][BitWidth-1:0] push_data_i,
    input  logic                                   pop_ready_i,
    output logic                                   pop_valid_o,
`ifdef BR_FLOW_MUX_SELECT_REG_SOURCE_ID_EN
    output logic [SelWidth-1:0]                    pop_source_o,
`endif
    output logic [BitWidth-1:0]                    pop_data_o
);

    // Encoding is {main_valid, skid_valid}, so valid bits read directly off the state flops.
    typedef enum logic [1:0] {
        StEmpty = 2'b00,
        StOne   = 2'b10,
        StFull  = 2'b11
    } state_e;

    state_e state_q, state_d;

    logic main_valid;
    logic skid_valid;
    logic buf_ready;
    logic sel_in_range;
    logic push;
    logic pop;

    logic [BitWidth-1:0] push_data_sel;
    logic [BitWidth-1:0] main_data_q, main_data_d;
    logic [BitWidth-1:0] skid_data_q, skid_data_d;

    logic load_main_push;
    logic load_main_skid;
    logic load_skid_push;

    assign main_valid   = state_q[1];
    assign skid_valid   = state_q[0];
    assign buf_ready    = !skid_valid;
    assign sel_in_range = 32'(select_i) < NumRequesters;

    // Decode select into per-requester ready and steer the selected payload.
    always_comb begin
        push_ready_o  = '0;
        push_data_sel = '0;
        for (int i = 0; i < int'(NumRequesters); i++) begin
            if (rst_n && buf_ready && sel_in_range && (select_i == SelWidth'(i))) begin
                push_ready_o[i] = 1'b1;
                push_data_sel   = push_data_i[i];
            end
        end
    end

    assign push = |(push_valid_i & push_ready_o);
    assign pop  = main_valid && pop_ready_i;

    // Occupancy state register; synchronous reset drops both entries.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Occupancy next-state from push/pop handshakes.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (push) begin
                    state_d = StOne;
                end
            end
            StOne: begin
                if (push && !pop) begin
                    state_d = StFull;
                end else if (pop && !push) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                if (pop) begin
                    state_d = StOne;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // Datapath load enables and registered outputs derived from the current state.
    always_comb begin
        load_main_push = 1'b0;
        load_main_skid = 1'b0;
        load_skid_push = 1'b0;
        unique case (state_q)
            StEmpty: load_main_push = push;
            // Push with pop refills main directly; push without pop parks in skid.
            StOne: begin
                load_main_push = push && pop;
                load_skid_push = push && !pop;
            end
            StFull:  load_main_skid = pop;
            default: ;
        endcase
        pop_valid_o = main_valid;
        pop_data_o  = main_data_q;
    end

    // Next-state of the payload entries.
    always_comb begin
        main_data_d = main_data_q;
        skid_data_d = skid_data_q;
        if (load_main_push) begin
            main_data_d = push_data_sel;
        end else if (load_main_skid) begin
            main_data_d = skid_data_q;
        end
        if (load_skid_push) begin
            skid_data_d = push_data_sel;
        end
    end

    // Payload flops carry no reset; their contents only matter while the valid bits say so.
    always_ff @(posedge clk) begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
    end

`ifdef BR_FLOW_MUX_SELECT_REG_SOURCE_ID_EN
    logic [SelWidth-1:0] main_src_q, main_src_d;
    logic [SelWidth-1:0] skid_src_q, skid_src_d;

    // Source id follows its payload through main and skid.
    always_comb begin
        main_src_d = main_src_q;
        skid_src_d = skid_src_q;
        if (load_main_push) begin
            main_src_d = select_i;
        end else if (load_main_skid) begin
            main_src_d = skid_src_q;
        end
        if (load_skid_push) begin
            skid_src_d = select_i;
        end
    end

    // Source id flops, unreset like the payload.
    always_ff @(posedge clk) begin
        main_src_q <= main_src_d;
        skid_src_q <= skid_src_d;
    end

    assign pop_source_o = main_src_q;
`endif

`ifndef SYNTHESIS
    a_params_legal: assert property (@(posedge clk)
        (NumRequesters >= 2) && (BitWidth >= 1))
        else $error("illegal parameters: NumRequesters=%0d BitWidth=%0d",
                    NumRequesters, BitWidth);

    a_select_in_range: assert property (@(posedge clk)
        rst_n |-> sel_in_range)
        else $error("select out of range: %0d", select_i);

    a_pop_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (pop_valid_o && !pop_ready_i) |=> (pop_valid_o && $stable(pop_data_o)))
        else $error("pop interface changed under backpressure");

`ifdef BR_FLOW_MUX_SELECT_REG_SOURCE_ID_EN
    a_pop_source_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (pop_valid_o && !pop_ready_i) |=> $stable(pop_source_o))
        else $error("pop_source changed under backpressure");
`endif

    a_push_ready_onehot0: assert property (@(posedge clk) $onehot0(push_ready_o))
        else $error("push_ready not onehot0: %b", push_ready_o);

    a_no_push_when_full: assert property (@(posedge clk)
        (state_q == StFull) |-> !push)
        else $error("push accepted while full");
`endif

endmodule

// File: tb/tb_br_flow_mux_select_reg.sv
// Testbench for br_flow_mux_select_reg: directed scenarios plus randomized traffic,
// all checked every cycle against a queue-based model of a 2-deep FIFO.

module tb_br_flow_mux_select_reg;

    localparam int unsigned N = 4;
    localparam int unsigned W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [1:0]       select;
    logic [N-1:0]     push_ready;
    logic [N-1:0]     push_valid;
    logic [N-1:0][W-1:0] push_data;
    logic             pop_ready;
    logic             pop_valid;
    logic [W-1:0]     pop_data;
`ifdef BR_FLOW_MUX_SELECT_REG_SOURCE_ID_EN
    logic [1:0]       pop_source;
`endif

    always #5 clk = ~clk;

    br_flow_mux_select_reg #(
        .NumRequesters(N),
        .BitWidth     (W)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .select_i    (select),
        .push_ready_o(push_ready),
        .push_valid_i(push_valid),
        .push_data_i (push_data),
        .pop_ready_i (pop_ready),
        .pop_valid_o (pop_valid),
`ifdef BR_FLOW_MUX_SELECT_REG_SOURCE_ID_EN
        .pop_source_o(pop_source),
`endif
        .pop_data_o  (pop_data)
    );

    typedef struct {
        logic [W-1:0] data;
        logic [1:0]   src;
    } ent_t;

    ent_t model_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   chk_en = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check against the model, advance the model at posedge.
    task automatic cycle(input logic rst, input logic [1:0] sel, input logic [N-1:0] pv,
                         input logic [31:0] pd, input logic pr);
        logic [N-1:0] exp_ready;
        bit           do_pop;
        bit           do_push;
        ent_t         e;
        @(negedge clk);
        rst_n      = rst;
        select     = sel;
        push_valid = pv;
        push_data  = pd;
        pop_ready  = pr;
        #1;
        if (chk_en) begin
            check_eq("pop_valid", 32'(pop_valid), 32'(model_q.size() > 0));
            if (model_q.size() > 0) begin
                check_eq("pop_data", 32'(pop_data), 32'(model_q[0].data));
`ifdef BR_FLOW_MUX_SELECT_REG_SOURCE_ID_EN
                check_eq("pop_source", 32'(pop_source), 32'(model_q[0].src));
`endif
            end
            exp_ready = (rst && model_q.size() < 2) ? (N'(1) << sel) : '0;
            check_eq("push_ready", 32'(push_ready), 32'(exp_ready));
        end
        @(posedge clk);
        if (!rst) begin
            model_q.delete();
        end else begin
            do_pop  = (model_q.size() > 0) && pr;
            do_push = (model_q.size() < 2) && pv[sel];
            e.data  = pd[sel*W +: W];
            e.src   = sel;
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(e);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cycle(1'b1, 2'd0, '0, 32'h0, 1'b1);
    endtask

    initial begin
        rst_n      = 1'b0;
        select     = 2'd1;
        push_valid = '1;
        push_data  = '0;
        pop_ready  = 1'b0;

        // Reset/idle: first cycle has unknown prior state, then check push_ready/pop_valid low.
        cycle(1'b0, 2'd1, 4'hF, 32'hA5A5A5A5, 1'b0);
        chk_en = 1'b1;
        cycle(1'b0, 2'd1, 4'hF, 32'hA5A5A5A5, 1'b0);
        cycle(1'b0, 2'd1, 4'hF, 32'hA5A5A5A5, 1'b0);
        cycle(1'b1, 2'd1, 4'b0010, 32'h0000A500, 1'b1);
        #1;
        check_eq("reset_release_valid", 32'(pop_valid), 32'd1);
        check_eq("reset_release_data", 32'(pop_data), 32'hA5);
        drain();

        // Streaming: one transfer per cycle, 1-cycle latency, no bubbles.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 2'(i), 4'hF, 32'h13121110, 1'b1);
            #1;
            check_eq("stream_valid", 32'(pop_valid), 32'd1);
            check_eq("stream_data", 32'(pop_data), 32'h10 + 32'(i));
        end
        drain();

        // Backpressure fill, blocked push on another requester, then ordered drain.
        cycle(1'b1, 2'd0, 4'b0001, 32'h00000001, 1'b0);
        cycle(1'b1, 2'd0, 4'b0001, 32'h00000002, 1'b0);
        cycle(1'b1, 2'd2, 4'b0100, 32'h00990000, 1'b0);
        #1;
        check_eq("full_ready", 32'(push_ready), 32'd0);
        check_eq("full_hold", 32'(pop_data), 32'h01);
        cycle(1'b1, 2'd2, 4'b0100, 32'h00990000, 1'b1);
        #1;
        check_eq("first_pop_next", 32'(pop_data), 32'h02);
        check_eq("ready_returns", 32'(push_ready), 32'b0100);
        drain();

        // Simultaneous push and pop while holding one entry.
        cycle(1'b1, 2'd1, 4'b0010, 32'h00003300, 1'b0);
        cycle(1'b1, 2'd1, 4'b0010, 32'h00004400, 1'b1);
        #1;
        check_eq("pushpop_data", 32'(pop_data), 32'h44);
        check_eq("pushpop_one", 32'(push_ready), 32'b0010);
        drain();

        // Mid-operation reset discards a full buffer.
        cycle(1'b1, 2'd3, 4'b1000, 32'h55000000, 1'b0);
        cycle(1'b1, 2'd3, 4'b1000, 32'h66000000, 1'b0);
        cycle(1'b0, 2'd3, 4'b0000, 32'h0, 1'b0);
        #1;
        check_eq("midreset_valid", 32'(pop_valid), 32'd0);
        cycle(1'b1, 2'd3, 4'b0000, 32'h0, 1'b1);
        drain();

`ifdef BR_FLOW_MUX_SELECT_REG_SOURCE_ID_EN
        cycle(1'b1, 2'd3, 4'b1000, 32'h77000000, 1'b0);
        cycle(1'b1, 2'd1, 4'b0010, 32'h00008800, 1'b0);
        #1;
        check_eq("src_first", 32'(pop_source), 32'd3);
        check_eq("src_first_data", 32'(pop_data), 32'h77);
        cycle(1'b1, 2'd0, 4'b0000, 32'h0, 1'b1);
        #1;
        check_eq("src_second", 32'(pop_source), 32'd1);
        check_eq("src_second_data", 32'(pop_data), 32'h88);
        drain();
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) != 0), 2'($urandom_range(0, 3)),
                  4'($urandom), $urandom, ($urandom_range(0, 3) != 0) ^ (i[8] & i[7]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/br_flow_mux_select_reg.md
Name: br_flow_mux_select_reg

Overview:
- Registered, full-throughput dataflow mux with explicit select.
- Steers one of NumRequesters ready-valid push interfaces to a single pop interface through an internal 2-entry elastic buffer (main + skid).
- pop_valid, pop_data and push_ready are driven from flops, with no combinational path from pop_ready or push_valid, so the block can sit on timing-critical channel boundaries.
- Pop side obeys ready-valid stability even when select changes.

Parameters:
- NumRequesters, 2, number of push interfaces; must be >= 2.
- BitWidth, 1, payload width; must be >= 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- select  input  $clog2(NumRequesters)  index of the requester eligible to transfer this cycle.
- push_ready  output  NumRequesters  per-requester ready.
- push_valid  input  NumRequesters  per-requester valid.
- push_data  input  NumRequesters x BitWidth  per-requester payload.
- pop_ready  input  1  downstream ready.
- pop_valid  output  1  output valid (registered).
- pop_data  output  BitWidth  output payload (registered).

Behaviour:
- Reset (rst_n==0 at a clk edge): main_valid=0, skid_valid=0, so pop_valid=0. push_ready is 0 while rst_n==0. Data flops need no reset. Reset mid-operation discards both entries with no pop.
- buf_ready = !skid_valid (flop output).
- push_ready[i] = rst_n && buf_ready && (select==i).
- A push on requester i occurs when push_valid[i] && push_ready[i]. At most one push per cycle.
- A pop occurs when pop_valid && pop_ready. pop_valid = main_valid; pop_data = main_data.
- State machine on occupancy {EMPTY, ONE, FULL} (main_valid, skid_valid):
  - EMPTY: push -> ONE, main <= push data.
  - ONE, push and no pop -> FULL, skid <= push data.
  - ONE, push and pop -> ONE, main <= push data.
  - ONE, pop only -> EMPTY.
  - ONE, neither -> hold.
  - FULL: push_ready all 0. Pop -> ONE, main <= skid. No pop -> hold.
- Latency: 1 cycle from push to pop_valid when EMPTY.
- Throughput: 1 transfer/cycle sustained when pop_ready is held high.
- Ordering: strict FIFO across both entries regardless of select changes.
- Once pop_valid=1, pop_valid and pop_data stay stable until popped.
- select may change every cycle. It affects only which push_ready bit asserts and never affects the buffered data.
- select >= NumRequesters: push_ready all 0, no push. This case is also an integration assertion violation.
- Assertions:
  - Static: NumRequesters >= 2 and BitWidth >= 1.
  - Integration: select in range when rst_n==1.
  - Implementation: pop_valid/pop_data stable under backpressure; $onehot0(push_ready); no push when FULL.

Optional Feature:
- Macro: BR_FLOW_MUX_SELECT_REG_SOURCE_ID_EN.
- Defined:
  - Adds output port pop_source, width $clog2(NumRequesters).
  - Carries the select value captured at push time, stored alongside main/skid data and moved main<=skid with it.
  - Subject to the same stability rule as pop_data. Not reset.
- Undefined:
  - Port absent, no extra flops.
  - All other behaviour identical.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles with push_valid='1, select=1 -> push_ready=0, pop_valid=0. On release with pop_ready=1, data 0xA5 on requester 1 appears at pop one cycle later.
- Streaming: NumRequesters=4, select cycles 0,1,2,3 each cycle, all push_valid=1, data=0x10+i, pop_ready=1 -> pop_data 0x10,0x11,0x12,0x13 on consecutive cycles, each 1 cycle after its push. No bubbles.
- Backpressure fill: pop_ready=0, push 0x01 then 0x02 on select=0 -> FULL, push_ready=0. Change select to 2 with push_valid[2]=1 -> no push, pop_data holds 0x01. Raise pop_ready -> 0x01, 0x02 popped in order, push_ready[2] returns the cycle after the first pop.
- Simultaneous push/pop in ONE: occupancy 1 holding 0x33, push 0x44 with pop_ready=1 -> 0x33 popped, next cycle pop_data=0x44, still ONE.
- Mid-operation reset: FULL with 0x55/0x66, assert rst_n=0 one cycle -> next cycle pop_valid=0. 0x55/0x66 are never popped.
- Feature on: pushes from select=3 (0x77) then select=1 (0x88) under pop_ready=0 -> pop_source=3 with 0x77, then 1 with 0x88 after the first pop.
